// File: rtl/barrel_shift_arbiter.sv
// rtl/barrel_shift_arbiter.sv - round-robin arbiter sequencing requesters onto one registered barrel shifter
module barrel_shift_arbiter #(
  parameter int NREQ          = 4,
  parameter int BUSWIDTH      = 16,
  parameter int SHIFTWIDTH    = 4,
  parameter int SHIFT_LATENCY = 1,
  parameter int IDW           = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*BUSWIDTH-1:0]   req_data,
  input  logic [NREQ*SHIFTWIDTH-1:0] req_shift_val,
  input  logic [NREQ-1:0]            req_rotation,
  input  logic [NREQ-1:0]            req_direction,
  output logic [BUSWIDTH-1:0]        sh_data_in,
  output logic [SHIFTWIDTH-1:0]      sh_shift_val,
  output logic                       sh_rotation,
  output logic                       sh_direction,
  input  logic [BUSWIDTH-1:0]        sh_data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [BUSWIDTH-1:0]        rsp_data,
  output logic                       busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [IDW-1:0]        r_rr_ptr;
  logic [IDW-1:0]        r_tag;
  logic [2:0]            r_cnt;
  logic [BUSWIDTH-1:0]   r_sh_data_in;
  logic [SHIFTWIDTH-1:0] r_sh_shift_val;
  logic                  r_sh_rotation;
  logic                  r_sh_direction;
  logic                  r_rsp_valid;
  logic [IDW-1:0]        r_rsp_id;
  logic [BUSWIDTH-1:0]   r_rsp_data;

  logic                  w_found;
  logic [IDW-1:0]        w_winner;

  // Modulo-NREQ increment; NREQ need not be a power of two.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign req_ready    = (rst_n && r_state == S_IDLE && w_found) ? (NREQ'(1) << w_winner) : '0;
  assign sh_data_in   = r_sh_data_in;
  assign sh_shift_val = r_sh_shift_val;
  assign sh_rotation  = r_sh_rotation;
  assign sh_direction = r_sh_direction;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_data     = r_rsp_data;
  assign busy         = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_tag          <= '0;
      r_cnt          <= '0;
      r_sh_data_in   <= '0;
      r_sh_shift_val <= '0;
      r_sh_rotation  <= 1'b0;
      r_sh_direction <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sh_data_in   <= req_data[w_winner*BUSWIDTH +: BUSWIDTH];
            r_sh_shift_val <= req_shift_val[w_winner*SHIFTWIDTH +: SHIFTWIDTH];
            r_sh_rotation  <= req_rotation[w_winner];
            r_sh_direction <= req_direction[w_winner];
            r_tag          <= w_winner;
            r_rr_ptr       <= wrap_add(w_winner, 1);
            r_cnt          <= 3'(SHIFT_LATENCY);
            r_state        <= S_WAIT;
          end
        end
        // First WAIT cycle presents operands; result is ready once the counter drains.
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rsp_data  <= sh_data_out;
            r_rsp_id    <= r_tag;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb/tb_barrel_shift_arbiter.sv - directed checks of barrel_shift_arbiter with a registered shifter model
module tb_barrel_shift_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  req_valid, req_ready, req_rotation, req_direction;
  logic [63:0] req_data;
  logic [15:0] req_shift_val;
  logic [15:0] sh_data_in, sh_data_out, rsp_data;
  logic [3:0]  sh_shift_val;
  logic        sh_rotation, sh_direction, rsp_valid, rsp_ready, busy;
  logic [1:0]  rsp_id;

  logic [2:0]  t3_valid, t3_ready, t3_rot, t3_dir;
  logic [47:0] t3_data;
  logic [11:0] t3_shift;
  logic [15:0] t3_sh_in, t3_sh_out, t3_rsp_data;
  logic [3:0]  t3_sh_shift;
  logic        t3_sh_rot, t3_sh_dir, t3_rsp_valid, t3_busy;
  logic [1:0]  t3_rsp_id;

  barrel_shift_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift_val(req_shift_val), .req_rotation(req_rotation),
    .req_direction(req_direction), .sh_data_in(sh_data_in), .sh_shift_val(sh_shift_val),
    .sh_rotation(sh_rotation), .sh_direction(sh_direction), .sh_data_out(sh_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy));

  barrel_shift_arbiter #(.NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(t3_valid), .req_ready(t3_ready),
    .req_data(t3_data), .req_shift_val(t3_shift), .req_rotation(t3_rot),
    .req_direction(t3_dir), .sh_data_in(t3_sh_in), .sh_shift_val(t3_sh_shift),
    .sh_rotation(t3_sh_rot), .sh_direction(t3_sh_dir), .sh_data_out(t3_sh_out),
    .rsp_valid(t3_rsp_valid), .rsp_ready(1'b1), .rsp_id(t3_rsp_id), .rsp_data(t3_rsp_data),
    .busy(t3_busy));

  function automatic logic [15:0] shf(input logic [15:0] d, input logic [3:0] s,
                                      input logic rot, input logic dir);
    logic [31:0] w;
    w = {d, d};
    if (!dir) begin
      w = w << s;
      return rot ? w[31:16] : (d << s);
    end else begin
      w = w >> s;
      return rot ? w[15:0] : (d >> s);
    end
  endfunction

  always @(posedge clk) begin
    sh_data_out <= shf(sh_data_in, sh_shift_val, sh_rotation, sh_direction);
    t3_sh_out   <= shf(t3_sh_in, t3_sh_shift, t3_sh_rot, t3_sh_dir);
  end

  typedef struct {
    int          id;
    logic [15:0] d;
    logic [3:0]  s;
    logic        rot;
    logic        dir;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[4];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic set_payload(input vec_t v);
    req_data[v.id*16 +: 16]     = v.d;
    req_shift_val[v.id*4 +: 4]  = v.s;
    req_rotation[v.id]          = v.rot;
    req_direction[v.id]         = v.dir;
  endtask

  task automatic set_t3(input int id, input vec_t v);
    t3_data[id*16 +: 16]  = v.d;
    t3_shift[id*4 +: 4]   = v.s;
    t3_rot[id]            = v.rot;
    t3_dir[id]            = v.dir;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] order[5];
    int at[5];
    int ng;
    logic seen;

    vt[0] = '{0, 16'h88ab, 4'd1,  1'b1, 1'b0, 16'h1157};
    vt[1] = '{2, 16'h9126, 4'd8,  1'b1, 1'b1, 16'h2691};
    vt[2] = '{3, 16'h3124, 4'd2,  1'b0, 1'b0, 16'hC490};
    vt[3] = '{1, 16'h29ce, 4'd10, 1'b0, 1'b1, 16'h000A};

    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_shift_val = '0; req_rotation = '0; req_direction = '0;
    rsp_ready = 1'b1;
    t3_valid = '0; t3_data = '0; t3_shift = '0; t3_rot = '0; t3_dir = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_payload(vt[i]);
      req_valid = 4'(1 << vt[i].id);
      #1;
      check($sformatf("v%0d_grant", i), 32'(req_ready), 32'(1 << vt[i].id));
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      @(negedge clk);
      req_valid = '0;
      #1;
      check($sformatf("v%0d_sh_data", i), 32'(sh_data_in), 32'(vt[i].d));
      check($sformatf("v%0d_sh_shift", i), 32'(sh_shift_val), 32'(vt[i].s));
      check($sformatf("v%0d_wait_busy", i), 32'(busy), 32'd1);
      check($sformatf("v%0d_early_rsp1", i), 32'(rsp_valid), 32'd0);
      @(negedge clk); #1;
      check($sformatf("v%0d_early_rsp2", i), 32'(rsp_valid), 32'd0);
      @(negedge clk); #1;
      check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vt[i].id));
      check($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vt[i].exp));
      @(negedge clk); #1;
      check($sformatf("v%0d_back_idle", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_rsp_dropped", i), 32'(rsp_valid), 32'd0);
    end

    // Reset in the middle of WAIT drops the operation.
    @(negedge clk);
    set_payload(vt[0]);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sh_data", 32'(sh_data_in), 32'd0);
    check("rst_sh_shift", 32'(sh_shift_val), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      seen = seen | rsp_valid | busy;
    end
    check("rst_no_rsp_after", 32'(seen), 32'd0);

    // All requesters valid continuously: round-robin order and 4-cycle spacing.
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_payload(vt[i]);
    req_valid = 4'hF;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (req_ready != 4'd0) begin
        order[ng] = req_ready;
        at[ng] = c;
        ng++;
      end
      if (ng < 5) @(negedge clk);
    end
    @(negedge clk);
    req_valid = '0;
    check("rr_grant_count", 32'(ng), 32'd5);
    for (int k = 0; k < 5 && k < ng; k++) begin
      check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(1 << (k % 4)));
      if (k > 0) check($sformatf("rr_gap%0d", k), 32'(at[k] - at[k-1]), 32'd4);
    end
    repeat (6) @(negedge clk);

    // Backpressure: 5 stalled RESP cycles, accept on the 6th.
    rsp_ready = 1'b0;
    set_payload(vt[3]);
    req_valid = 4'b0010;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    set_payload(vt[2]);
    req_valid = 4'b1000;
    #1;
    check("bp_rsp_valid0", 32'(rsp_valid), 32'd1);
    check("bp_rsp_data0", 32'(rsp_data), 32'h000A);
    check("bp_rsp_id0", 32'(rsp_id), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_data%0d", k), 32'(rsp_data), 32'h000A);
      check($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd1);
      check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_accept_valid", 32'(rsp_valid), 32'd1);
    check("bp_accept_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_rsp", 32'(rsp_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    check("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_rsp_id", 32'(rsp_id), 32'd3);
    check("bp_next_rsp_data", 32'(rsp_data), 32'hC490);
    repeat (2) @(negedge clk);

    // NREQ=3: move rr_ptr to 2, then requesters 0 and 2 compete.
    set_t3(0, vt[0]);
    set_t3(1, vt[3]);
    set_t3(2, vt[1]);
    @(negedge clk);
    t3_valid = 3'b001;
    #1;
    check("n3_grant0", 32'(t3_ready), 32'b001);
    @(negedge clk);
    t3_valid = '0;
    repeat (3) @(negedge clk);
    t3_valid = 3'b010;
    #1;
    check("n3_grant1", 32'(t3_ready), 32'b010);
    @(negedge clk);
    t3_valid = '0;
    repeat (3) @(negedge clk);
    t3_valid = 3'b101;
    #1;
    check("n3_wrap_first", 32'(t3_ready), 32'b100);
    @(negedge clk);
    t3_valid = 3'b001;
    #1;
    check("n3_wait_ready", 32'(t3_ready), 32'b000);
    @(negedge clk);
    @(negedge clk); #1;
    check("n3_rsp_id2", 32'(t3_rsp_id), 32'd2);
    check("n3_rsp_data2", 32'(t3_rsp_data), 32'h2691);
    @(negedge clk); #1;
    check("n3_wrap_second", 32'(t3_ready), 32'b001);
    @(negedge clk);
    t3_valid = '0;
    @(negedge clk);
    @(negedge clk); #1;
    check("n3_rsp_valid0", 32'(t3_rsp_valid), 32'd1);
    check("n3_rsp_id0", 32'(t3_rsp_id), 32'd0);
    check("n3_rsp_data0", 32'(t3_rsp_data), 32'h1157);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
